// File: rtl/branch_unit.sv
// branch_unit: branch/jump execution unit fed by the branch reservation station.
// Captures one ready branch, resolves condition and target in a single EXEC
// cycle, issues a valid/ack redirect to fetch when taken, then pulses done.
// Optional build macro: BRANCH_STATS_EN adds stat_exec/stat_taken counters.

`ifndef ADDR_T
`define ADDR_T logic [31:0]
`endif
`ifndef WORD_T
`define WORD_T logic [31:0]
`endif
`ifndef SINST_T
`define SINST_T logic [2:0]
`endif
`ifndef REGTAG_T
`define REGTAG_T logic [3:0]
`endif
`ifndef UNLOCKED
`define UNLOCKED 4'd0
`endif
`ifndef BEQ
`define BEQ 3'd0
`endif
`ifndef BNE
`define BNE 3'd1
`endif
`ifndef BLT
`define BLT 3'd2
`endif
`ifndef BGE
`define BGE 3'd3
`endif
`ifndef BLTU
`define BLTU 3'd4
`endif
`ifndef BGEU
`define BGEU 3'd5
`endif
`ifndef JAL
`define JAL 3'd6
`endif
`ifndef JALR
`define JALR 3'd7
`endif

module branch_unit (
  input  logic      clk,
  input  logic      rst,
  input  `ADDR_T    pc_in,
  input  `WORD_T    offset_in,
  input  logic      busy_in,
  input  `SINST_T   op_in,
  input  `REGTAG_T  tagx_in,
  input  `REGTAG_T  tagy_in,
  input  `WORD_T    datax_in,
  input  `WORD_T    datay_in,
  output logic      busy_branch,
  output logic      redirect_valid,
  output `ADDR_T    redirect_pc,
  input  logic      redirect_ack,
  output logic      done,
  output logic      done_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_exec,
  output logic [31:0] stat_taken
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EXEC     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0] state_q, state_d;

  `ADDR_T  pc_q, pc_d;
  `WORD_T  off_q, off_d;
  `SINST_T op_q, op_d;
  `WORD_T  x_q, x_d;
  `WORD_T  y_q, y_d;

  logic    redirect_valid_q, redirect_valid_d;
  `ADDR_T  redirect_pc_q, redirect_pc_d;
  logic    done_q, done_d;
  logic    done_taken_q, done_taken_d;

  logic    capture;
  logic    cond_taken;
  `ADDR_T  pc_sum;
  `ADDR_T  reg_sum;
  `ADDR_T  target;

  // An entry is only accepted once both operands carry valid data.
  assign capture = busy_in && (tagx_in == `UNLOCKED) && (tagy_in == `UNLOCKED);

  // Resolve the branch condition from the latched operands.
  always_comb begin
    cond_taken = 1'b0;
    case (op_q)
      `BEQ:  cond_taken = (x_q == y_q);
      `BNE:  cond_taken = (x_q != y_q);
      `BLT:  cond_taken = ($signed(x_q) <  $signed(y_q));
      `BGE:  cond_taken = ($signed(x_q) >= $signed(y_q));
      `BLTU: cond_taken = (x_q <  y_q);
      `BGEU: cond_taken = (x_q >= y_q);
      `JAL:  cond_taken = 1'b1;
      `JALR: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // Compute the redirect target; sums wrap modulo 2^32 and JALR clears bit 0.
  always_comb begin
    pc_sum  = pc_q + off_q;
    reg_sum = x_q + off_q;
    if (op_q == `JALR) begin
      target = reg_sum & 32'hFFFF_FFFE;
    end else begin
      target = pc_sum;
    end
  end

  // Next-state logic for the FSM, operand latches and registered outputs.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    off_d            = off_q;
    op_d             = op_q;
    x_d              = x_q;
    y_d              = y_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    done_d           = 1'b0;
    done_taken_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_EXEC;
          pc_d    = pc_in;
          off_d   = offset_in;
          op_d    = op_in;
          x_d     = datax_in;
          y_d     = datay_in;
        end
      end
      ST_EXEC: begin
        if (cond_taken) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
        end else begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          done_taken_d = 1'b0;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ack) begin
          state_d          = ST_DONE;
          redirect_valid_d = 1'b0;
          done_d           = 1'b1;
          done_taken_d     = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and output registers; reset discards any in-flight branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      pc_q             <= '0;
      off_q            <= '0;
      op_q             <= '0;
      x_q              <= '0;
      y_q              <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      done_q           <= 1'b0;
      done_taken_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      off_q            <= off_d;
      op_q             <= op_d;
      x_q              <= x_d;
      y_q              <= y_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      done_q           <= done_d;
      done_taken_q     <= done_taken_d;
    end
  end

  assign busy_branch    = (state_q == ST_EXEC) || (state_q == ST_REDIRECT);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign done           = done_q;
  assign done_taken     = done_taken_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_exec_q;
  logic [31:0] stat_taken_q;

  // Count completions as each done pulse retires; counters wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_exec_q  <= '0;
      stat_taken_q <= '0;
    end else if (done_q) begin
      stat_exec_q <= stat_exec_q + 32'd1;
      if (done_taken_q) begin
        stat_taken_q <= stat_taken_q + 32'd1;
      end
    end
  end

  assign stat_exec  = stat_exec_q;
  assign stat_taken = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed-vector bench for branch_unit with hand-computed
// expected targets, handshake timing and asynchronous reset behaviour.

`ifndef ADDR_T
`define ADDR_T logic [31:0]
`endif
`ifndef WORD_T
`define WORD_T logic [31:0]
`endif
`ifndef SINST_T
`define SINST_T logic [2:0]
`endif
`ifndef REGTAG_T
`define REGTAG_T logic [3:0]
`endif
`ifndef UNLOCKED
`define UNLOCKED 4'd0
`endif
`ifndef BEQ
`define BEQ 3'd0
`endif
`ifndef BNE
`define BNE 3'd1
`endif
`ifndef BLT
`define BLT 3'd2
`endif
`ifndef BGE
`define BGE 3'd3
`endif
`ifndef BLTU
`define BLTU 3'd4
`endif
`ifndef BGEU
`define BGEU 3'd5
`endif
`ifndef JAL
`define JAL 3'd6
`endif
`ifndef JALR
`define JALR 3'd7
`endif

module tb_branch_unit;

  logic      clk;
  logic      rst;
  `ADDR_T    pc_in;
  `WORD_T    offset_in;
  logic      busy_in;
  `SINST_T   op_in;
  `REGTAG_T  tagx_in;
  `REGTAG_T  tagy_in;
  `WORD_T    datax_in;
  `WORD_T    datay_in;
  logic      busy_branch;
  logic      redirect_valid;
  `ADDR_T    redirect_pc;
  logic      redirect_ack;
  logic      done;
  logic      done_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_exec;
  logic [31:0] stat_taken;
`endif

  int total = 0;
  int bad   = 0;

  branch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .offset_in      (offset_in),
    .busy_in        (busy_in),
    .op_in          (op_in),
    .tagx_in        (tagx_in),
    .tagy_in        (tagy_in),
    .datax_in       (datax_in),
    .datay_in       (datay_in),
    .busy_branch    (busy_branch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ack   (redirect_ack),
    .done           (done),
    .done_taken     (done_taken)
`ifdef BRANCH_STATS_EN
    ,
    .stat_exec      (stat_exec),
    .stat_taken     (stat_taken)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ready entry and let the unit capture it on the next edge
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                               input logic [31:0] x, input logic [31:0] y);
    op_in     = op;
    pc_in     = pc;
    offset_in = off;
    datax_in  = x;
    datay_in  = y;
    tagx_in   = `UNLOCKED;
    tagy_in   = `UNLOCKED;
    busy_in   = 1'b1;
    tick();
    busy_in   = 1'b0;
  endtask

  // Full transaction: capture, resolve, optional redirect with immediate ack, done
  task automatic runBranch(input string name, input logic [2:0] op, input logic [31:0] pc,
                           input logic [31:0] off, input logic [31:0] x, input logic [31:0] y,
                           input logic expTaken, input logic [31:0] expPc);
    applyStimulus(op, pc, off, x, y);
    checkOutput({name, ".busyT0"}, {31'd0, busy_branch}, 32'd1);
    tick();
    if (expTaken) begin
      checkOutput({name, ".rvalid"}, {31'd0, redirect_valid}, 32'd1);
      checkOutput({name, ".rpc"}, redirect_pc, expPc);
      redirect_ack = 1'b1;
      tick();
      redirect_ack = 1'b0;
      checkOutput({name, ".done"}, {31'd0, done}, 32'd1);
      checkOutput({name, ".taken"}, {31'd0, done_taken}, 32'd1);
      checkOutput({name, ".rvalidDrop"}, {31'd0, redirect_valid}, 32'd0);
    end else begin
      checkOutput({name, ".done"}, {31'd0, done}, 32'd1);
      checkOutput({name, ".taken"}, {31'd0, done_taken}, 32'd0);
      checkOutput({name, ".noRedirect"}, {31'd0, redirect_valid}, 32'd0);
    end
    checkOutput({name, ".busyDone"}, {31'd0, busy_branch}, 32'd0);
    tick();
    checkOutput({name, ".donePulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    pc_in        = '0;
    offset_in    = '0;
    busy_in      = 1'b0;
    op_in        = '0;
    tagx_in      = `UNLOCKED;
    tagy_in      = `UNLOCKED;
    datax_in     = '0;
    datay_in     = '0;
    redirect_ack = 1'b0;

    #3;
    checkOutput("rst.busy", {31'd0, busy_branch}, 32'd0);
    checkOutput("rst.rvalid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("rst.rpc", redirect_pc, 32'd0);
    checkOutput("rst.done", {31'd0, done}, 32'd0);
    checkOutput("rst.taken", {31'd0, done_taken}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic taken BEQ with full timing
    runBranch("beq", `BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120);
    // Signed vs unsigned compare on the same operands
    runBranch("blt", `BLT, 32'h400, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h410);
    runBranch("bltu", `BLTU, 32'h400, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    runBranch("bgeu", `BGEU, 32'h500, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h4F0);
    runBranch("bge", `BGE, 32'h500, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    runBranch("bne", `BNE, 32'h600, 32'h4, 32'd7, 32'd9, 1'b1, 32'h604);
    runBranch("beqNt", `BEQ, 32'h600, 32'h4, 32'd7, 32'd9, 1'b0, 32'h0);
    // Jumps and address wrap
    runBranch("jal", `JAL, 32'h800, 32'h40, 32'd0, 32'd0, 1'b1, 32'h840);
    runBranch("jalr", `JALR, 32'h900, 32'h4, 32'h1003, 32'd0, 1'b1, 32'h1006);
    runBranch("wrap", `BEQ, 32'hFFFF_FFF0, 32'h20, 32'd3, 32'd3, 1'b1, 32'h10);

    // Locked operand holds off capture
    op_in     = `BNE;
    pc_in     = 32'h700;
    offset_in = 32'h8;
    datax_in  = 32'd1;
    datay_in  = 32'd1;
    tagx_in   = `UNLOCKED;
    tagy_in   = 4'd5;
    busy_in   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("lock.busy", {31'd0, busy_branch}, 32'd0);
    end
    tagy_in = `UNLOCKED;
    tick();
    busy_in = 1'b0;
    checkOutput("lock.capture", {31'd0, busy_branch}, 32'd1);
    tick();
    checkOutput("lock.done", {31'd0, done}, 32'd1);
    checkOutput("lock.taken", {31'd0, done_taken}, 32'd0);
    tick();

    // Ack withheld for 4 cycles: request stays stable
    applyStimulus(`BGE, 32'h200, 32'h8, 32'd5, 32'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold.rvalid", {31'd0, redirect_valid}, 32'd1);
      checkOutput("hold.rpc", redirect_pc, 32'h208);
      checkOutput("hold.busy", {31'd0, busy_branch}, 32'd1);
      tick();
    end
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    checkOutput("hold.done", {31'd0, done}, 32'd1);
    checkOutput("hold.taken", {31'd0, done_taken}, 32'd1);
    tick();

    // Reset in the 2nd cycle of a pending redirect
    applyStimulus(`JAL, 32'h300, 32'h10, 32'd0, 32'd0);
    tick();
    checkOutput("arst.pre", {31'd0, redirect_valid}, 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.rvalid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("arst.busy", {31'd0, busy_branch}, 32'd0);
    checkOutput("arst.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("arst.idle", {31'd0, busy_branch}, 32'd0);
    checkOutput("arst.idleRv", {31'd0, redirect_valid}, 32'd0);
    runBranch("post", `BNE, 32'hA00, 32'h8, 32'd1, 32'd2, 1'b1, 32'hA08);

`ifdef BRANCH_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    runBranch("s1", `BEQ, 32'h0, 32'h4, 32'd1, 32'd1, 1'b1, 32'h4);
    runBranch("s2", `BNE, 32'h0, 32'h4, 32'd1, 32'd1, 1'b0, 32'h0);
    runBranch("s3", `JAL, 32'h10, 32'h4, 32'd0, 32'd0, 1'b1, 32'h14);
    runBranch("s4", `BLTU, 32'h0, 32'h4, 32'd9, 32'd2, 1'b0, 32'h0);
    runBranch("s5", `BGEU, 32'h0, 32'h8, 32'd9, 32'd2, 1'b1, 32'h8);
    checkOutput("stat.exec", stat_exec, 32'd5);
    checkOutput("stat.taken", stat_taken, 32'd3);
    force dut.stat_exec_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_exec_q;
    runBranch("s6", `BEQ, 32'h0, 32'h4, 32'd1, 32'd2, 1'b0, 32'h0);
    checkOutput("stat.wrap", stat_exec, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
